// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file, scoreboard hazard stall,
// and a one-entry valid/ready output register feeding the ALU.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [2:0]        in_aluop,
  input  logic [4:0]        in_rd,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_aluop,
  output logic [4:0]        out_rd
);

  logic [DATA_W-1:0] grf [32];
  logic [31:0]       sb;

  logic hit_rs, hit_rt, hit_rd;
  logic busy_rs, busy_rt, busy_rd;
  logic hazard, accept;
  logic [DATA_W-1:0] rs_val, rt_val, b_nxt;

  assign hit_rs = BYPASS && wb_en && (wb_addr == in_rs);
  assign hit_rt = BYPASS && wb_en && (wb_addr == in_rt);
  assign hit_rd = BYPASS && wb_en && (wb_addr == in_rd);

  // A same-cycle writeback retires the pending bit early
  assign busy_rs = (in_rs != 5'd0) && sb[in_rs] && !hit_rs;
  assign busy_rt = (in_rt != 5'd0) && sb[in_rt] && !hit_rt;
  assign busy_rd = (in_rd != 5'd0) && sb[in_rd] && !hit_rd;

  assign hazard   = busy_rs || (!in_use_imm && busy_rt) || busy_rd;
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    rs_val = grf[in_rs];
    if (in_rs == 5'd0)
      rs_val = '0;
    else if (hit_rs)
      rs_val = wb_data;
  end

  always_comb begin
    rt_val = grf[in_rt];
    if (in_rt == 5'd0)
      rt_val = '0;
    else if (hit_rt)
      rt_val = wb_data;
  end

  assign b_nxt = in_use_imm ? in_imm : rt_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        grf[i] <= '0;
    end else if (wb_en && wb_addr != 5'd0) begin
      grf[wb_addr] <= wb_data;
    end
  end

  // Set after clear: a new issue to the same rd keeps it pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb <= '0;
    end else begin
      if (wb_en)
        sb[wb_addr] <= 1'b0;
      if (accept && in_rd != 5'd0)
        sb[in_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_aluop <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= rs_val;
      out_b     <= b_nxt;
      out_aluop <= in_aluop;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic
// checked every cycle against a register/pending-set model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_aluop;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_aluop;
  logic [4:0]  out_rd;

  operand_fetch #(.DATA_W(32), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_aluop(in_aluop), .in_rd(in_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_aluop(out_aluop), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_reg [32];
  bit          m_pend [32];
  bit          m_ov;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  logic [4:0]  m_rd;
  logic        seen_ready;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_reg[r];
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return r != 0 && m_pend[r] && !(wb_en && wb_addr == r);
  endfunction

  function automatic bit m_ready();
    bit stall;
    stall = m_busy(in_rs) || (!in_use_imm && m_busy(in_rt)) || m_busy(in_rd);
    return !stall && (!m_ov || out_ready);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_ov = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
  endtask

  task automatic check_out();
    chk("out_valid", out_valid, m_ov);
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_aluop", out_aluop, m_op);
    chk("out_rd", out_rd, m_rd);
  endtask

  // Entered at posedge+1 with inputs driven; leaves at next posedge+1
  task automatic step();
    bit acc;
    logic [31:0] na, nb;
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = m_ready();
    seen_ready = in_ready;
    chk("in_ready", in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    na = m_read(in_rs);
    nb = in_use_imm ? in_imm : m_read(in_rt);
    @(posedge clk);
    if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
    if (wb_en) m_pend[wb_addr] = 1'b0;
    if (acc) begin
      m_ov = 1; m_a = na; m_b = nb; m_op = in_aluop; m_rd = in_rd;
      if (in_rd != 0) m_pend[in_rd] = 1'b1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    #1;
    check_out();
  endtask

  task automatic cyc(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [31:0] imm, input bit ui, input logic [2:0] op,
                     input logic [4:0] rd, input bit we, input logic [4:0] wa,
                     input logic [31:0] wd, input bit ordy);
    in_valid = v; in_rs = rs; in_rt = rt; in_imm = imm;
    in_use_imm = ui; in_aluop = op; in_rd = rd;
    wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    m_clear();
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int q[$];
    reset = 1'b1;
    in_valid = 0; in_rs = 0; in_rt = 0; in_imm = 0; in_use_imm = 0;
    in_aluop = 0; in_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    out_ready = 1;
    m_clear();
    #1;
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset with a held entry drops it and clears the file
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 5, 32'hAAAA_5555, 1);
    cyc(1, 5, 0, 32'h1, 1, 3'd2, 0, 0, 0, 0, 0);
    chk("pre_reset_valid", out_valid, 1'b1);
    chk("pre_reset_a", out_a, 32'hAAAA_5555);
    do_reset();
    cyc(1, 5, 0, 32'h1, 1, 0, 0, 0, 0, 0, 1);
    chk("r5_after_reset", out_a, 32'h0);

    // Basic immediate issue
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 3, 32'h10, 1);
    cyc(1, 3, 0, 32'hFFFF_FFF0, 1, 3'b000, 0, 0, 0, 0, 1);
    chk("imm_a", out_a, 32'h10);
    chk("imm_b", out_b, 32'hFFFF_FFF0);
    chk("imm_valid", out_valid, 1'b1);

    // RAW stall released by same-cycle writeback with bypass
    cyc(1, 0, 0, 0, 1, 3'd1, 4, 0, 0, 0, 1);
    chk("rd4_accept", seen_ready, 1'b1);
    cyc(1, 4, 0, 0, 1, 3'd1, 0, 0, 0, 0, 1);
    chk("raw_stall1", seen_ready, 1'b0);
    cyc(1, 4, 0, 0, 1, 3'd1, 0, 0, 0, 0, 1);
    chk("raw_stall2", seen_ready, 1'b0);
    cyc(1, 4, 0, 0, 1, 3'd1, 0, 1, 4, 32'h1234, 1);
    chk("raw_release", seen_ready, 1'b1);
    chk("raw_bypass_a", out_a, 32'h1234);

    // Register 0 stays zero; rd=0 never stalls
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hDEAD, 1);
    cyc(1, 0, 0, 32'h55, 0, 3'd3, 0, 0, 0, 0, 1);
    chk("r0_a", out_a, 32'h0);
    chk("r0_b", out_b, 32'h0);
    cyc(1, 0, 0, 32'h7, 1, 3'd4, 0, 0, 0, 0, 1);
    chk("rd0_follow", seen_ready, 1'b1);

    // Backpressure holds payload, then back-to-back transfers
    idle();
    cyc(1, 3, 0, 32'hCAFE_0001, 1, 3'd5, 9, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 32'h100 + i, 1, 3'd6, 0, 0, 0, 0, 0);
      chk("bp_ready", seen_ready, 1'b0);
      chk("bp_a", out_a, 32'h10);
      chk("bp_b", out_b, 32'hCAFE_0001);
      chk("bp_rd", out_rd, 32'd9);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 32'h200 + i, 1, 3'd7, 0, 0, 0, 0, 1);
      chk("b2b_ready", seen_ready, 1'b1);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_b", out_b, 32'h200 + i);
    end
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 9, 32'h99, 1);

    // WAW stall on rd=7; pending again after the second issue
    cyc(1, 0, 0, 0, 1, 0, 7, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1, 0, 7, 0, 0, 0, 1);
    chk("waw_stall", seen_ready, 1'b0);
    cyc(1, 0, 0, 0, 1, 0, 7, 1, 7, 32'h77, 1);
    chk("waw_release", seen_ready, 1'b1);
    cyc(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("waw_still_pending", seen_ready, 1'b0);
    cyc(0, 0, 0, 0, 1, 0, 0, 1, 7, 32'h78, 1);

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      bit we;
      logic [4:0] wa;
      q.delete();
      for (int i = 1; i < 32; i++)
        if (m_pend[i]) q.push_back(i);
      we = 0; wa = 0;
      if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
        we = 1;
        wa = 5'(q[$urandom_range(0, q.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        we = 1;
        wa = 5'($urandom_range(0, 7));
      end
      cyc($urandom_range(0, 9) < 7,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          $urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), we, wa, $urandom,
          $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
